eth_cmd_sequencer: RTL and testbench



---
 rtl/eth_cmd_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_eth_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_cmd_sequencer.sv
// eth_cmd_sequencer: edge-detects header-decoder strobes and runs the IDLE/ARMED/RUN/DRAIN acquisition FSM.
// It also routes data packets to the payload handler. Define CMD_SEQ_WDOG_EN to build the sync-loss frame watchdog.

module eth_cmd_sequencer #(
    parameter logic [31:0] WDOG_CYCLES = 32'd1_000_000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             sclr_n,
    input  logic             is_type_1,
    input  logic             is_type_2,
    input  logic             is_type_2_2,
    input  logic             is_start_signal,
    input  logic             is_stop_signal,
    input  logic             is_sync_signal,
    input  logic             handler_busy,
    output logic             acq_run,
    output logic             armed,
    output logic             sync_pulse,
    output logic             route_valid,
    output logic [1:0]       route_type,
    output logic             drop,
    output logic [CNT_W-1:0] drop_count,
    output logic             err_sync_lost
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DRAIN
    } state_e;

    logic [5:0]       strb;
    logic [5:0]       strb_q;
    logic [5:0]       rise;
    logic             ev_stop;
    logic             ev_start;
    logic             ev_sync;
    logic             ev_data;
    logic [1:0]       data_type;
    logic             wdog_expired;

    state_e           state_q;
    logic             acq_run_q;
    logic             armed_q;
    logic             sync_pulse_q;
    logic             route_valid_q;
    logic [1:0]       route_type_q;
    logic             drop_q;
    logic [CNT_W-1:0] drop_count_q;
    logic             err_q;

    assign strb = {is_stop_signal, is_start_signal, is_sync_signal,
                   is_type_2_2, is_type_2, is_type_1};
    assign rise = strb & ~strb_q;

    // Only the highest-priority event survives: stop > start > sync > data.
    always_comb begin
        ev_stop   = rise[5];
        ev_start  = rise[4] & ~rise[5];
        ev_sync   = rise[3] & ~(|rise[5:4]);
        ev_data   = (|rise[2:0]) & ~(|rise[5:3]);
        data_type = 2'd2;
        if (rise[0]) begin
            data_type = 2'd0;
        end else if (rise[1]) begin
            data_type = 2'd1;
        end
    end

`ifdef CMD_SEQ_WDOG_EN
    logic [31:0] wdog_q;

    assign wdog_expired = (state_q == ST_RUN) && (wdog_q == 32'd0);

    // A sync always reloads, so it beats a simultaneous expiry.
    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            wdog_q <= '0;
        end else if (ev_sync && (state_q == ST_ARMED || state_q == ST_RUN)) begin
            wdog_q <= WDOG_CYCLES - 32'd1;
        end else if (state_q == ST_RUN && !ev_stop && !wdog_expired) begin
            wdog_q <= wdog_q - 32'd1;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = ^WDOG_CYCLES;
    assign wdog_expired    = 1'b0;
`endif

    // NOTE: the edge registers are reset too, so a strobe still high after reset reads as a fresh event.
    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            strb_q        <= '0;
            state_q       <= ST_IDLE;
            acq_run_q     <= 1'b0;
            armed_q       <= 1'b0;
            sync_pulse_q  <= 1'b0;
            route_valid_q <= 1'b0;
            route_type_q  <= 2'd0;
            drop_q        <= 1'b0;
            drop_count_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            strb_q        <= strb;
            sync_pulse_q  <= 1'b0;
            route_valid_q <= 1'b0;
            drop_q        <= 1'b0;

            if (ev_data) begin
                if (state_q == ST_RUN && !handler_busy) begin
                    route_valid_q <= 1'b1;
                    route_type_q  <= data_type;
                end else begin
                    drop_q <= 1'b1;
                    if (drop_count_q != '1) begin
                        drop_count_q <= drop_count_q + CNT_W'(1);
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (ev_start) begin
                        state_q <= ST_ARMED;
                        armed_q <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (ev_stop) begin
                        state_q <= ST_IDLE;
                        armed_q <= 1'b0;
                    end else if (ev_sync) begin
                        state_q      <= ST_RUN;
                        armed_q      <= 1'b0;
                        acq_run_q    <= 1'b1;
                        sync_pulse_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ev_stop) begin
                        state_q   <= ST_DRAIN;
                        acq_run_q <= 1'b0;
                    end else if (ev_sync) begin
                        sync_pulse_q <= 1'b1;
                    end else if (wdog_expired) begin
                        state_q   <= ST_IDLE;
                        acq_run_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!handler_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    acq_run_q <= 1'b0;
                    armed_q   <= 1'b0;
                end
            endcase
        end
    end

    assign acq_run       = acq_run_q;
    assign armed         = armed_q;
    assign sync_pulse    = sync_pulse_q;
    assign route_valid   = route_valid_q;
    assign route_type    = route_type_q;
    assign drop          = drop_q;
    assign drop_count    = drop_count_q;
    assign err_sync_lost = err_q;

endmodule

// File: tb/tb_eth_cmd_sequencer.sv
// Directed self-checking bench for eth_cmd_sequencer (WDOG_CYCLES = 100, CNT_W = 2).
// The output vector compared by outs() is {acq_run, armed, sync_pulse, route_valid, drop}.

module tb_eth_cmd_sequencer;

    localparam logic [31:0] WDOG  = 32'd100;
    localparam int unsigned CW    = 2;
    localparam int          T1    = 0;
    localparam int          T2    = 1;
    localparam int          T22   = 2;
    localparam int          SYNC  = 3;
    localparam int          START = 4;
    localparam int          STOP  = 5;

    logic          clock        = 1'b0;
    logic          sclr_n       = 1'b0;
    logic          handler_busy = 1'b0;
    logic [5:0]    strb         = '0;
    logic          acq_run;
    logic          armed;
    logic          sync_pulse;
    logic          route_valid;
    logic [1:0]    route_type;
    logic          drop;
    logic [CW-1:0] drop_count;
    logic          err_sync_lost;

    int n_checks = 0;
    int n_errors = 0;

    eth_cmd_sequencer #(
        .WDOG_CYCLES (WDOG),
        .CNT_W       (CW)
    ) dut (
        .clock           (clock),
        .sclr_n          (sclr_n),
        .is_type_1       (strb[T1]),
        .is_type_2       (strb[T2]),
        .is_type_2_2     (strb[T22]),
        .is_start_signal (strb[START]),
        .is_stop_signal  (strb[STOP]),
        .is_sync_signal  (strb[SYNC]),
        .handler_busy    (handler_busy),
        .acq_run         (acq_run),
        .armed           (armed),
        .sync_pulse      (sync_pulse),
        .route_valid     (route_valid),
        .route_type      (route_type),
        .drop            (drop),
        .drop_count      (drop_count),
        .err_sync_lost   (err_sync_lost)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({acq_run, armed, sync_pulse, route_valid, drop});
    endfunction

    // Inputs change and outputs are sampled 1 ns after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held with start high; the stale level arms on the first active edge.
        strb[START] = 1'b1;
        step(3);
        chk("rst_outs", outs(), 32'b00000);
        chk("rst_err", 32'(err_sync_lost), 32'd0);
        chk("rst_cnt", 32'(drop_count), 32'd0);
        sclr_n = 1'b1;
        step(1);
        chk("rst_stale_start", outs(), 32'b01000);
        strb[START] = 1'b0;
        step(1);

        // Normal run: sync, three type_2 packets, stop.
        strb[SYNC] = 1'b1;
        step(1);
        chk("run_entry", outs(), 32'b10100);
        strb[SYNC] = 1'b0;
        step(1);
        chk("sync_one_cycle", outs(), 32'b10000);
        for (int i = 0; i < 3; i++) begin
            strb[T2] = 1'b1;
            step(1);
            chk("route_valid", outs(), 32'b10010);
            chk("route_type", 32'(route_type), 32'd1);
            strb[T2] = 1'b0;
            step(1);
            chk("route_low", outs(), 32'b10000);
        end
        strb[STOP] = 1'b1;
        step(1);
        chk("stop_drain", outs(), 32'b00000);
        strb[STOP] = 1'b0;
        step(1);
        chk("run_no_drops", 32'(drop_count), 32'd0);

        // Stop beats sync; DRAIN holds while busy and ignores start.
        strb[START] = 1'b1;
        step(1);
        chk("arm_again", outs(), 32'b01000);
        strb[START] = 1'b0;
        strb[SYNC]  = 1'b1;
        step(1);
        chk("run_again", outs(), 32'b10100);
        strb[SYNC] = 1'b0;
        step(1);
        handler_busy = 1'b1;
        strb[STOP]   = 1'b1;
        strb[SYNC]   = 1'b1;
        step(1);
        chk("stop_over_sync", outs(), 32'b00000);
        strb = '0;
        step(1);
        strb[START] = 1'b1;
        step(1);
        chk("drain_ignores_start", outs(), 32'b00000);
        strb[START] = 1'b0;
        step(7);
        handler_busy = 1'b0;
        step(1);
        strb[START] = 1'b1;
        step(1);
        chk("idle_after_drain", outs(), 32'b01000);
        strb[START] = 1'b0;

        // Busy refusal in RUN, refusal in IDLE, then saturation at 3.
        strb[SYNC] = 1'b1;
        step(1);
        strb[SYNC]   = 1'b0;
        handler_busy = 1'b1;
        strb[T1]     = 1'b1;
        step(1);
        chk("busy_drop", outs(), 32'b10001);
        chk("cnt_1", 32'(drop_count), 32'd1);
        strb[T1]     = 1'b0;
        handler_busy = 1'b0;
        step(1);
        chk("drop_one_cycle", outs(), 32'b10000);
        strb[STOP] = 1'b1;
        step(1);
        strb[STOP] = 1'b0;
        step(1);
        strb[T22] = 1'b1;
        step(1);
        chk("idle_drop", outs(), 32'b00001);
        chk("cnt_2", 32'(drop_count), 32'd2);
        strb[T22] = 1'b0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            strb[T1] = 1'b1;
            step(1);
            chk("sat_drop", outs(), 32'b00001);
            strb[T1] = 1'b0;
            step(1);
        end
        chk("cnt_saturated", 32'(drop_count), 32'd3);
        chk("route_type_held", 32'(route_type), 32'd1);

        // Start and data together: data is ignored and not refused.
        strb[START] = 1'b1;
        strb[T2]    = 1'b1;
        step(1);
        chk("start_over_data", outs(), 32'b01000);
        strb = '0;
        step(1);

        strb[SYNC] = 1'b1;
        step(1);
        chk("wd_entry", outs(), 32'b10100);
        strb[SYNC] = 1'b0;
`ifdef CMD_SEQ_WDOG_EN
        step(99);
        chk("wd_before_expiry", outs(), 32'b10000);
        chk("wd_no_err_yet", 32'(err_sync_lost), 32'd0);
        step(1);
        chk("wd_expire", outs(), 32'b00000);
        chk("wd_err_set", 32'(err_sync_lost), 32'd1);
        strb[START] = 1'b1;
        step(1);
        chk("err_clear_arm", outs(), 32'b01000);
        chk("err_cleared", 32'(err_sync_lost), 32'd0);
        strb[START] = 1'b0;
        strb[SYNC]  = 1'b1;
        step(1);
        strb[SYNC] = 1'b0;
        step(98);
        strb[SYNC] = 1'b1;
        step(1);
        chk("sync_at_99", outs(), 32'b10100);
        strb[SYNC] = 1'b0;
        step(99);
        chk("wd_reloaded", outs(), 32'b10000);
        chk("wd_reload_no_err", 32'(err_sync_lost), 32'd0);
`else
        step(1000);
        chk("no_wd_still_run", outs(), 32'b10000);
        chk("no_wd_no_err", 32'(err_sync_lost), 32'd0);
`endif
        strb[STOP] = 1'b1;
        step(1);
        chk("final_stop", outs(), 32'b00000);
        strb = '0;
        step(2);

        // Reset mid-packet: outputs clear, a held start re-arms afterwards.
        strb[START] = 1'b1;
        step(1);
        chk("pre_reset_arm", outs(), 32'b01000);
        sclr_n = 1'b0;
        step(1);
        chk("mid_reset_outs", outs(), 32'b00000);
        chk("mid_reset_cnt", 32'(drop_count), 32'd0);
        sclr_n = 1'b1;
        step(1);
        chk("post_reset_edge", outs(), 32'b01000);
        strb = '0;
        step(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
